// File: rtl/alu_exec_unit_if.sv
// Operation/result handshake bundle for alu_exec_unit.
// The slave modport is the ALU side and the master modport is the pipeline side.
interface alu_exec_unit_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            o_ready;
  logic [3:0]      i_alu_ctrl;
  logic [XLEN-1:0] i_op_a;
  logic [XLEN-1:0] i_op_b;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_result;
  logic            o_illegal;

  modport slave (
    input  i_valid, i_alu_ctrl, i_op_a, i_op_b, i_ready,
    output o_ready, o_valid, o_result, o_illegal
  );

  modport master (
    output i_valid, i_alu_ctrl, i_op_a, i_op_b, i_ready,
    input  o_ready, o_valid, o_result, o_illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready in and out. Shifts run one bit per cycle,
// unless ALU_FAST_SHIFT_EN is defined, which selects a single-cycle barrel shifter.
module alu_exec_unit #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_flush,
  alu_exec_unit_if.slave bus
);
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_AND  = 4'b1001;
  localparam logic [3:0] OP_EQ   = 4'b1010;
  localparam logic [3:0] OP_GE   = 4'b1011;
  localparam logic [3:0] OP_GEU  = 4'b1100;
  localparam logic [3:0] OP_BUF  = 4'b1101;

  localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};
  localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};
  localparam logic [XLEN-2:0]    PAD_ZERO = {(XLEN-1){1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t              state_r, state_nx;
  logic                ready_s, accept_s, is_shift_s, iter_s, alu_ill_s;
  logic [SHAMT_W-1:0]  shamt_s, cnt_r;
  logic [XLEN-1:0]     a_s, b_s, alu_res_s, sh_r, sh_nx_s, result_r;
  logic [3:0]          op_r;
  logic                illegal_r, valid_r;

  assign a_s        = bus.i_op_a;
  assign b_s        = bus.i_op_b;
  assign shamt_s    = bus.i_op_b[SHAMT_W-1:0];
  assign ready_s    = ((state_r == ST_IDLE) | ((state_r == ST_DONE) & bus.i_ready)) & ~i_flush;
  assign accept_s   = bus.i_valid & ready_s;
  assign is_shift_s = (bus.i_alu_ctrl == OP_SLL) | (bus.i_alu_ctrl == OP_SRL) |
                      (bus.i_alu_ctrl == OP_SRA);
`ifdef ALU_FAST_SHIFT_EN
  assign iter_s     = 1'b0;
`else
  assign iter_s     = is_shift_s & (shamt_s != CNT_ZERO);
`endif

  assign bus.o_ready   = ready_s;
  assign bus.o_valid   = valid_r;
  assign bus.o_result  = result_r;
  assign bus.o_illegal = illegal_r;

  // Single-cycle datapath; in the iterative build it only covers a zero shift amount.
  always_comb begin
    alu_res_s = {XLEN{1'b0}};
    alu_ill_s = 1'b0;
    case (bus.i_alu_ctrl)
      OP_ADD:  alu_res_s = a_s + b_s;
      OP_SUB:  alu_res_s = a_s - b_s;
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL:  alu_res_s = a_s << shamt_s;
      OP_SRL:  alu_res_s = a_s >> shamt_s;
      OP_SRA:  alu_res_s = $signed(a_s) >>> shamt_s;
`else
      OP_SLL, OP_SRL, OP_SRA: alu_res_s = a_s;
`endif
      OP_SLT:  alu_res_s = {PAD_ZERO, ($signed(a_s) < $signed(b_s))};
      OP_SLTU: alu_res_s = {PAD_ZERO, (a_s < b_s)};
      OP_XOR:  alu_res_s = a_s ^ b_s;
      OP_OR:   alu_res_s = a_s | b_s;
      OP_AND:  alu_res_s = a_s & b_s;
      OP_EQ:   alu_res_s = {PAD_ZERO, (a_s == b_s)};
      OP_GE:   alu_res_s = {PAD_ZERO, ($signed(a_s) >= $signed(b_s))};
      OP_GEU:  alu_res_s = {PAD_ZERO, (a_s >= b_s)};
      OP_BUF:  alu_res_s = b_s;
      default: begin
        alu_res_s = {XLEN{1'b0}};
        alu_ill_s = 1'b1;
      end
    endcase
  end

  // One-bit shift step applied to the in-flight operand.
  always_comb begin
    sh_nx_s = sh_r;
    case (op_r)
      OP_SLL:  sh_nx_s = {sh_r[XLEN-2:0], 1'b0};
      OP_SRL:  sh_nx_s = {1'b0, sh_r[XLEN-1:1]};
      OP_SRA:  sh_nx_s = {sh_r[XLEN-1], sh_r[XLEN-1:1]};
      default: sh_nx_s = sh_r;
    endcase
  end

  // Next-state logic; flush overrides both handshakes.
  always_comb begin
    state_nx = state_r;
    if (i_flush) begin
      state_nx = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) state_nx = iter_s ? ST_SHIFT : ST_DONE;
          else          state_nx = ST_IDLE;
        end
        ST_SHIFT: begin
          // Counter 1 means this edge performs the last shift.
          if ((cnt_r == CNT_ONE) | (cnt_r == CNT_ZERO)) state_nx = ST_DONE;
          else                                          state_nx = ST_SHIFT;
        end
        ST_DONE: begin
          if (accept_s)         state_nx = iter_s ? ST_SHIFT : ST_DONE;
          else if (bus.i_ready) state_nx = ST_IDLE;
          else                  state_nx = ST_DONE;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_r <= ST_IDLE;
    else          state_r <= state_nx;
  end

  // Result, shift operand and counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_r   <= 1'b0;
      result_r  <= {XLEN{1'b0}};
      illegal_r <= 1'b0;
      sh_r      <= {XLEN{1'b0}};
      cnt_r     <= CNT_ZERO;
      op_r      <= 4'b0000;
    end else if (i_flush) begin
      valid_r <= 1'b0;
      cnt_r   <= CNT_ZERO;
    end else begin
      valid_r <= (state_nx == ST_DONE);
      if (accept_s) begin
        if (iter_s) begin
          sh_r  <= a_s;
          cnt_r <= shamt_s;
          op_r  <= bus.i_alu_ctrl;
        end else begin
          result_r  <= alu_res_s;
          illegal_r <= alu_ill_s;
        end
      end else if (state_r == ST_SHIFT) begin
        sh_r  <= sh_nx_s;
        cnt_r <= cnt_r - CNT_ONE;
        if (state_nx == ST_DONE) begin
          result_r  <= sh_nx_s;
          illegal_r <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases, randomized ops against
// an arithmetic reference model, backpressure, flush and async reset.
module tb_alu_exec_unit;
  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_exec_unit_if #(.XLEN(32)) bus();

  alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (flush),
    .bus     (bus)
  );

  // Reference: {illegal, result} straight from the operation definitions.
  function automatic logic [32:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    logic        il;
    int          s;
    s  = int'(b[4:0]);
    il = 1'b0;
    case (c)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a << s;
      4'd3:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:    r = (a < b) ? 32'd1 : 32'd0;
      4'd5:    r = a ^ b;
      4'd6:    r = a >> s;
      4'd7:    r = $signed(a) >>> s;
      4'd8:    r = a | b;
      4'd9:    r = a & b;
      4'd10:   r = (a == b) ? 32'd1 : 32'd0;
      4'd11:   r = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      4'd12:   r = (a >= b) ? 32'd1 : 32'd0;
      4'd13:   r = b;
      default: begin r = 32'd0; il = 1'b1; end
    endcase
    return {il, r};
  endfunction

  // Edges from the edge preceding the handshake cycle until o_valid is seen.
  function automatic int ref_lat(input logic [3:0] c, input logic [31:0] b);
`ifdef ALU_FAST_SHIFT_EN
    return 1;
`else
    if (c == 4'd2 || c == 4'd6 || c == 4'd7) return 1 + int'(b[4:0]);
    return 1;
`endif
  endfunction

  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input string name);
    logic [32:0] exp;
    int waits;
    int lat;
    exp = ref_alu(c, a, b);
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_alu_ctrl = c; bus.i_op_a = a; bus.i_op_b = b;
    #1;
    waits = 0;
    while (bus.o_ready !== 1'b1 && waits < 200) begin
      @(negedge clk); #1; waits++;
    end
    checks++;
    if (waits >= 200) begin
      failures++; $display("FAIL %s accept_timeout ready=%b required=1", name, bus.o_ready);
    end
    @(posedge clk); #1;
    bus.i_valid = 1'b0; bus.i_op_a = $urandom; bus.i_op_b = $urandom;
    bus.i_alu_ctrl = 4'($urandom);
    lat = 1;
    @(negedge clk);
    while (bus.o_valid !== 1'b1 && lat < 100) begin
      checks++;
      if (bus.o_ready !== 1'b0) begin
        failures++; $display("FAIL %s busy_ready got=%b required=0", name, bus.o_ready);
      end
      @(negedge clk); lat++;
    end
    checks++;
    if (lat != ref_lat(c, b)) begin
      failures++; $display("FAIL %s latency got=%0d required=%0d", name, lat, ref_lat(c, b));
    end
    checks++;
    if (bus.o_result !== exp[31:0]) begin
      failures++; $display("FAIL %s result got=%h required=%h", name, bus.o_result, exp[31:0]);
    end
    checks++;
    if (bus.o_illegal !== exp[32]) begin
      failures++; $display("FAIL %s illegal got=%b required=%b", name, bus.o_illegal, exp[32]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; bus.i_valid = 1'b0; bus.i_ready = 1'b1;
    bus.i_alu_ctrl = 4'd0; bus.i_op_a = 32'd0; bus.i_op_b = 32'd0;
    #12;
    checks += 3;
    if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b required=0", bus.o_valid); end
    if (bus.o_result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h required=0", bus.o_result); end
    if (bus.o_illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b required=0", bus.o_illegal); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++;
    if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b required=1", bus.o_ready); end
  endtask

  task automatic test_directed();
    run_op(4'd0,  32'h7FFF_FFFF, 32'h0000_0001, "add_overflow");
    run_op(4'd7,  32'h8000_0000, 32'h0000_0004, "sra_4");
    run_op(4'd4,  32'h0000_0001, 32'hFFFF_FFFF, "sltu");
    run_op(4'd11, 32'h0000_0001, 32'hFFFF_FFFF, "ge_signed");
    run_op(4'd10, 32'h0000_0005, 32'h0000_0005, "eq");
    run_op(4'd15, $urandom, $urandom, "illegal_1111");
    run_op(4'd14, $urandom, $urandom, "illegal_1110");
    run_op(4'd2,  32'hDEAD_BEEF, 32'hFFFF_FFE0, "sll_shamt0_upper_bits");
    run_op(4'd13, $urandom, 32'h1234_5678, "buf");
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    bus.i_ready = 1'b0; bus.i_valid = 1'b1; bus.i_alu_ctrl = 4'd5;
    bus.i_op_a = 32'hF0F0_F0F0; bus.i_op_b = 32'hFFFF_0000;
    @(posedge clk); #1;
    bus.i_alu_ctrl = 4'd0; bus.i_op_a = 32'd100; bus.i_op_b = 32'd23;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks += 3;
      if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL bp_valid cyc=%0d got=%b required=1", i, bus.o_valid); end
      if (bus.o_result !== 32'h0F0F_F0F0) begin failures++; $display("FAIL bp_hold cyc=%0d got=%h required=0f0ff0f0", i, bus.o_result); end
      if (bus.o_ready !== 1'b0) begin failures++; $display("FAIL bp_ready cyc=%0d got=%b required=0", i, bus.o_ready); end
    end
    bus.i_ready = 1'b1; #1;
    checks++;
    if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b required=1", bus.o_ready); end
    @(posedge clk); #1; bus.i_valid = 1'b0;
    @(negedge clk);
    checks += 2;
    if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b required=1", bus.o_valid); end
    if (bus.o_result !== 32'd123) begin failures++; $display("FAIL b2b_result got=%h required=0000007b", bus.o_result); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_alu_ctrl = 4'd2; bus.i_op_a = $urandom; bus.i_op_b = 32'd20;
    @(posedge clk); #1; bus.i_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); flush = 1'b1; #1;
    checks++;
    if (bus.o_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b required=0", bus.o_ready); end
    @(posedge clk); #1; flush = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      checks += 2;
      if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL flush_valid cyc=%0d got=%b required=0", i, bus.o_valid); end
      if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL flush_idle cyc=%0d got=%b required=1", i, bus.o_ready); end
    end
    run_op(4'd1, 32'd5, 32'd9, "after_flush_sub");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      run_op(4'($urandom_range(0, 15)), $urandom, $urandom, "random");
    end
  endtask

  task automatic test_async_reset();
    run_op(4'd0, 32'd5, 32'd7, "pre_reset_add");
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_alu_ctrl = 4'd6; bus.i_op_a = $urandom; bus.i_op_b = 32'd10;
    @(posedge clk); #1; bus.i_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    checks += 3;
    if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%b required=0", bus.o_valid); end
    if (bus.o_result !== 32'd0) begin failures++; $display("FAIL areset_result got=%h required=0", bus.o_result); end
    if (bus.o_illegal !== 1'b0) begin failures++; $display("FAIL areset_illegal got=%b required=0", bus.o_illegal); end
    @(negedge clk); rst_n = 1'b1;
    run_op(4'd9, 32'hFF00_FF00, 32'h0FF0_0FF0, "post_reset_and");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
